// File: rtl/encoder_4to2_reg.sv
// Registered 4-to-2 priority encoder with a one-deep
// valid/ready output slot and a saturating multi-hot error counter.
module encoder_4to2_reg #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e,
  input  logic [3:0]       d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       y,
  output logic             zero,
  output logic             multi,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  logic       accept;
  logic [1:0] y_n;
  logic       zero_n;
  logic       multi_n;

  assign out_valid = (state == FULL);
  // Held in reset so nothing is accepted mid-reset.
  assign in_ready  = ~rst & e & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;

  always_comb begin
    y_n = 2'd0;
    priority case (1'b1)
      d[3]:    y_n = 2'd3;
      d[2]:    y_n = 2'd2;
      d[1]:    y_n = 2'd1;
      default: y_n = 2'd0;
    endcase
  end

  assign zero_n  = (d == 4'b0000);
  assign multi_n = ($countones(d) >= 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      y       <= 2'd0;
      zero    <= 1'b0;
      multi   <= 1'b0;
      err_cnt <= '0;
    end else begin
      unique case (state)
        EMPTY: if (accept) state <= FULL;
        FULL:  if (!accept && out_ready) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (accept) begin
        y     <= y_n;
        zero  <= zero_n;
        multi <= multi_n;
      end
      if (clr)
        err_cnt <= '0;
      else if (accept && multi_n && err_cnt != CNT_MAX)
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
